// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Buffers ALU results in completion order until the writeback stage takes
//   them. Each entry holds {data, destination register, error flag}.
//
//   Optional feature (macro ALU_RESULT_BYPASS_EN): when the buffer is empty,
//   an incoming result is presented on wb_* in the same cycle. If writeback
//   takes it in that cycle, it is never written into the buffer.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clean     synchronous flush of all buffered results (beats push/pop)
//   in_valid  ALU result strobe
//   numC      ALU result data (64 bits)
//   in_reg    destination register index
//   in_err    invalid-function-select flag for this result
//   in_ready  buffer can accept a result this cycle
//   wb_valid  head entry available for writeback
//   wb_data   head entry data (0 when wb_valid is 0)
//   wb_reg    head entry destination index (0 when wb_valid is 0)
//   wb_err    head entry error flag (0 when wb_valid is 0)
//   wb_ready  writeback accepts the head entry this cycle
//   count     number of occupied entries
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int REG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clean,
  input  logic                     in_valid,
  input  logic [63:0]              numC,
  input  logic [REG_W-1:0]         in_reg,
  input  logic                     in_err,
  output logic                     in_ready,
  output logic                     wb_valid,
  output logic [63:0]              wb_data,
  output logic [REG_W-1:0]         wb_reg,
  output logic                     wb_err,
  input  logic                     wb_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int DATA_W = 64;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [REG_W-1:0]  reg_mem  [DEPTH];
  logic [DEPTH-1:0]  err_mem;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  logic              nonempty;
  logic              push;
  logic              pop;

  assign count    = count_q;
  assign nonempty = (count_q != '0);

  // A full buffer still accepts when the head leaves in the same cycle.
  assign in_ready = (count_q != FULL) || wb_ready;

`ifdef ALU_RESULT_BYPASS_EN
  logic bypass_act;
  logic bypass_take;

  // rst gates the bypass so outputs read zero for the whole reset window.
  assign bypass_act  = !rst && !nonempty && in_valid && !clean;
  assign bypass_take = bypass_act && wb_ready;
  assign push        = in_valid && in_ready && !clean && !bypass_take;
  assign wb_valid    = nonempty || bypass_act;
`else
  assign push        = in_valid && in_ready && !clean;
  assign wb_valid    = nonempty;
`endif

  // Only a real buffered head is popped; a bypassed result never entered.
  assign pop = nonempty && wb_ready && !clean;

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clean) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: data only, no reset needed since reads are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= numC;
      reg_mem[wr_ptr]  <= in_reg;
      err_mem[wr_ptr]  <= in_err;
    end
  end

  // Head presentation; zero whenever nothing is valid.
  always_comb begin
    wb_data = '0;
    wb_reg  = '0;
    wb_err  = 1'b0;
    if (nonempty) begin
      wb_data = data_mem[rd_ptr];
      wb_reg  = reg_mem[rd_ptr];
      wb_err  = err_mem[rd_ptr];
    end
`ifdef ALU_RESULT_BYPASS_EN
    else if (bypass_act) begin
      wb_data = numC;
      wb_reg  = in_reg;
      wb_err  = in_err;
    end
`endif
  end

endmodule
